// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, FSM states and the
// {pc, inst} entry carried through the instruction queue.
package if_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN     = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    // Queue entries carry XLEN_DEF-bit PCs; the top's XLEN must not exceed it.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN-1:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous instruction queue of fetch entries with push, pop, flush and an
// occupancy count. Flush wins over a simultaneous push or pop.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, queues in-order responses
// for decode, and drops stale responses after a redirect. FETCH_BYPASS_EN adds 0-cycle bypass.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_inst
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUTST + 1) + 1;

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   discard, discard_next;
    logic [CW-1:0]   occ;
    logic            q_empty;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            req_fire, rsp_keep, bypass, push, pop;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign req_fire = mem_req_valid && mem_req_ready;
    assign rsp_keep = mem_rsp_valid && (state == ST_RUN) && !redirect_valid;

    // Stale requests will not occupy the queue, so they do not count against it.
    assign mem_req_valid = rst && !redirect_valid && (outst < OW'(MAX_OUTST)) &&
                           ((SW'(occ) + SW'(outst) - SW'(discard)) < SW'(DEPTH));
    assign mem_req_addr  = fetch_pc;

`ifdef FETCH_BYPASS_EN
    assign bypass = rst && q_empty && rsp_keep;
`else
    assign bypass = 1'b0;
`endif

    assign id_valid  = !q_empty || bypass;
    assign id_pc     = !q_empty ? XLEN'(head.pc) : (bypass ? rsp_pc : '0);
    assign id_inst   = !q_empty ? head.inst : (bypass ? mem_rsp_data : '0);
    assign pop       = !q_empty && id_ready && !redirect_valid;
    assign push      = rsp_keep && !(bypass && id_ready);
    assign push_data = '{pc: XLEN_DEF'(rsp_pc), inst: mem_rsp_data};

    if_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .empty     (q_empty),
        .count     (occ)
    );

    always_comb begin
        discard_next = discard;
        state_next   = state;
        // A response landing on the redirect edge retires one stale request already.
        if (redirect_valid) begin
            discard_next = outst - OW'(mem_rsp_valid);
        end else if (mem_rsp_valid && (discard != '0)) begin
            discard_next = discard - OW'(1);
        end
        case (state)
            ST_RUN:   if (discard_next != '0) state_next = ST_FLUSH;
            ST_FLUSH: if (discard_next == '0) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            discard <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    // rsp_pc is the PC of the next kept response; responses return in request order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            outst    <= '0;
        end else begin
            outst <= outst + OW'(req_fire) - OW'(mem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_keep) rsp_pc   <= rsp_pc + XLEN'(4);
            end
        end
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_OUTST, default 2, meaning maximum outstanding memory requests (1..DEPTH).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-005 SHALL have port clk  in  1  system clock; one clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port mem_req_valid  out  1  fetch request valid.
REQ-008 SHALL have port mem_req_ready  in  1  memory accepts request.
REQ-009 SHALL have port mem_req_addr  out  XLEN  fetch address, word aligned.
REQ-010 SHALL have port mem_rsp_valid  in  1  response valid; responses are in request order, one per accepted request, never back-pressured.
REQ-011 SHALL have port mem_rsp_data  in  32  instruction word.
REQ-012 SHALL have port redirect_valid  in  1  control-flow redirect from EX.
REQ-013 SHALL have port redirect_pc  in  XLEN  redirect target.
REQ-014 SHALL have port id_valid  out  1  instruction available to decode.
REQ-015 SHALL have port id_ready  in  1  decode accepts (stall when low).
REQ-016 SHALL have port id_pc  out  XLEN  PC of presented instruction.
REQ-017 SHALL have port id_inst  out  32  presented instruction.

Function
REQ-018 SHALL keep fetch_pc; each accepted request (mem_req_valid & mem_req_ready) sends fetch_pc and advances fetch_pc by 4 (mod 2^XLEN).
REQ-019 SHALL assert mem_req_valid only when outst < MAX_OUTST, occupancy + outst - discard < DEPTH, and redirect_valid is low.
REQ-020 SHALL push each non-discarded response with its PC (FIFO of request PCs, or fetch-order PC counter) into the queue; queue never overflows by REQ-019.
REQ-021 SHALL pop the head when id_valid & id_ready; id_valid = queue not empty (plus REQ-031 bypass).
REQ-022 SHALL, on redirect_valid, in the same edge: flush queue, set fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}, set discard = outst minus any response arriving that cycle.
REQ-023 SHALL drop responses while discard > 0, decrementing discard per response; dropped data never reaches id_*.
REQ-024 SHALL implement two states: RUN (discard == 0) and FLUSH (discard > 0); RUN->FLUSH on redirect with stale requests pending; FLUSH->RUN when last stale response is dropped; new requests MAY issue in FLUSH.
REQ-025 SHALL give redirect priority over a simultaneous pop or push: post-edge queue empty.
REQ-026 SHALL accept back-to-back redirects; the second retargets fetch_pc and recomputes discard per REQ-022.
REQ-027 SHALL update outst by +1 per accepted request, -1 per response, both same cycle = unchanged.
REQ-028 SHALL hold id_pc/id_inst stable while id_valid & !id_ready and no redirect.

Reset
REQ-029 SHALL, while rst low: fetch_pc = RESET_PC, queue empty, outst = 0, discard = 0, state RUN, mem_req_valid = 0, id_valid = 0, mem_req_addr = RESET_PC, id_pc = 0, id_inst = 0.
REQ-030 SHALL, on reset mid-operation, forget all in-flight requests; memory is reset together with this block.

Configuration
REQ-031 SHALL, with FETCH_BYPASS_EN defined, present a response combinationally on id_* when queue empty, discard == 0 and no redirect; if id_ready is high it is not enqueued (0-cycle latency response->decode).
REQ-032 SHALL, without FETCH_BYPASS_EN, always enqueue; id_valid rises at earliest one cycle after mem_rsp_valid.

Structure
REQ-033 SHALL take XLEN default, instruction width 32, default RESET_PC and the fetch-entry struct {pc, inst} from shared package if_pkg.
REQ-034 SHALL instantiate one sub-module if_fifo (synchronous FIFO, DEPTH entries, push/pop/flush, occupancy out).

Verification
REQ-035 SHALL test reset release, mem_req_ready=1, 1-cycle response latency: addresses 0,4,8,... issued; id_pc 0,4,8 in order with matching id_inst.
REQ-036 SHALL test id_ready held 0 with DEPTH=4: exactly 4 entries fill, mem_req_valid stays 0, head held stable; id_ready=1 drains in order.
REQ-037 SHALL test redirect to 0x103 with 2 requests outstanding: next 2 responses dropped, next id_pc = 0x100, mem_req_addr = 0x100.
REQ-038 SHALL test redirect in the same cycle as a pop and a response: queue empty after edge, discard = 1.
REQ-039 SHALL test redirects to 0x40 then 0x80 on consecutive cycles: only instructions from 0x80 onward appear.
REQ-040 SHALL test with and without FETCH_BYPASS_EN, queue empty, id_ready=1: id_valid same cycle as mem_rsp_valid (with) vs one cycle later (without).
